// File: rtl/vga_layer_pkg.sv
// Shared types and constants for the VGA overlay layer scheduler.
package vga_layer_pkg;

  localparam int RGB_W      = 12;
  localparam int ICON_WORDS = 2500;

  typedef enum logic [2:0] {
    LAYER_NONE,
    LAYER_BG,
    LAYER_IMG,
    LAYER_KEY_W,
    LAYER_KEY_A,
    LAYER_KEY_S,
    LAYER_KEY_D
  } layer_e;

endpackage

// File: rtl/vga_layer_sched_if.sv
// Pixel-timing inputs, ROM address/data pair and pixel output of the layer scheduler.
interface vga_layer_sched_if;
  import vga_layer_pkg::*;

  logic              frame_start;
  logic              valid;
  logic [9:0]        h_cnt;
  logic [9:0]        v_cnt;
  logic [3:0]        key_req;
  logic [14:0]       img_addr;
  logic [RGB_W-1:0]  img_data;
  logic [14:0]       spr_addr;
  logic [RGB_W-1:0]  spr_data;
  logic [RGB_W-1:0]  pixel;
  logic              pixel_valid;

  modport slave (
    input  frame_start, valid, h_cnt, v_cnt, key_req, img_data, spr_data,
    output img_addr, spr_addr, pixel, pixel_valid
  );

  modport master (
    output frame_start, valid, h_cnt, v_cnt, key_req, img_data, spr_data,
    input  img_addr, spr_addr, pixel, pixel_valid
  );

endinterface

// File: rtl/vga_win_hit.sv
// Rectangle hit test with inclusive start / exclusive end, plus offsets from the corner.
// Latency: combinational. Backpressure: none.
// Offsets are modulo-1024 and only meaningful when hit is set.
module vga_win_hit #(
  parameter int unsigned HS = 0,
  parameter int unsigned HE = 1,
  parameter int unsigned VS = 0,
  parameter int unsigned VE = 1
) (
  input  logic [9:0] h,
  input  logic [9:0] v,
  output logic       hit,
  output logic [9:0] dx,
  output logic [9:0] dy
);

  localparam logic [9:0] HS_L = 10'(HS);
  localparam logic [9:0] HE_L = 10'(HE);
  localparam logic [9:0] VS_L = 10'(VS);
  localparam logic [9:0] VE_L = 10'(VE);

  assign hit = (h >= HS_L) && (h < HE_L) && (v >= VS_L) && (v < VE_L);
  assign dx  = h - HS_L;
  assign dy  = v - VS_L;

endmodule

// File: rtl/vga_layer_sched.sv
// Per-pixel layer pick (WASD keys > image > background), ROM addressing, final RGB444 pixel.
// Latency: 3 clk from h_cnt/v_cnt/valid to pixel. Backpressure: none, runs every cycle.
// VGA_KEY_BLINK_EN: pressed icons blink, alternating every BLINK_FRAMES frames.
module vga_layer_sched
  import vga_layer_pkg::*;
#(
  parameter int unsigned      IMG_HS   = 60,
  parameter int unsigned      IMG_HE   = 240,
  parameter int unsigned      IMG_VS   = 60,
  parameter int unsigned      IMG_VE   = 220,
  parameter int unsigned      KEY_SZ   = 50,
  parameter int unsigned      W_H      = 150,
  parameter int unsigned      W_V      = 280,
  parameter int unsigned      A_H      = 100,
  parameter int unsigned      A_V      = 330,
  parameter int unsigned      S_H      = 150,
  parameter int unsigned      S_V      = 330,
  parameter int unsigned      D_H      = 200,
  parameter int unsigned      D_V      = 330,
`ifdef VGA_KEY_BLINK_EN
  parameter int unsigned      BLINK_FRAMES = 15,
`endif
  parameter logic [RGB_W-1:0] BG_COLOR = 12'hfd1
) (
  input logic               clk,
  input logic               rst_n,
  vga_layer_sched_if.slave  bus
);

  logic       img_hit;
  logic [9:0] img_dx, img_dy;
  logic [3:0] key_hit;
  logic [9:0] key_dx [4];
  logic [9:0] key_dy [4];

  vga_win_hit #(.HS(IMG_HS), .HE(IMG_HE), .VS(IMG_VS), .VE(IMG_VE)) u_hit_img (
    .h(bus.h_cnt), .v(bus.v_cnt), .hit(img_hit), .dx(img_dx), .dy(img_dy));
  vga_win_hit #(.HS(W_H), .HE(W_H + KEY_SZ), .VS(W_V), .VE(W_V + KEY_SZ)) u_hit_w (
    .h(bus.h_cnt), .v(bus.v_cnt), .hit(key_hit[0]), .dx(key_dx[0]), .dy(key_dy[0]));
  vga_win_hit #(.HS(A_H), .HE(A_H + KEY_SZ), .VS(A_V), .VE(A_V + KEY_SZ)) u_hit_a (
    .h(bus.h_cnt), .v(bus.v_cnt), .hit(key_hit[1]), .dx(key_dx[1]), .dy(key_dy[1]));
  vga_win_hit #(.HS(S_H), .HE(S_H + KEY_SZ), .VS(S_V), .VE(S_V + KEY_SZ)) u_hit_s (
    .h(bus.h_cnt), .v(bus.v_cnt), .hit(key_hit[2]), .dx(key_dx[2]), .dy(key_dy[2]));
  vga_win_hit #(.HS(D_H), .HE(D_H + KEY_SZ), .VS(D_V), .VE(D_V + KEY_SZ)) u_hit_d (
    .h(bus.h_cnt), .v(bus.v_cnt), .hit(key_hit[3]), .dx(key_dx[3]), .dy(key_dy[3]));

  layer_e     layer0;
  logic [9:0] dx0, dy0;
  logic [1:0] key_idx;
  logic       is_key0;

  // First matching window wins; W is tested first so it owns any overlap.
  always_comb begin
    layer0  = LAYER_NONE;
    dx0     = '0;
    dy0     = '0;
    key_idx = 2'd0;
    if (bus.valid) begin
      if (key_hit[0]) begin
        layer0 = LAYER_KEY_W; dx0 = key_dx[0]; dy0 = key_dy[0]; key_idx = 2'd0;
      end else if (key_hit[1]) begin
        layer0 = LAYER_KEY_A; dx0 = key_dx[1]; dy0 = key_dy[1]; key_idx = 2'd1;
      end else if (key_hit[2]) begin
        layer0 = LAYER_KEY_S; dx0 = key_dx[2]; dy0 = key_dy[2]; key_idx = 2'd2;
      end else if (key_hit[3]) begin
        layer0 = LAYER_KEY_D; dx0 = key_dx[3]; dy0 = key_dy[3]; key_idx = 2'd3;
      end else if (img_hit) begin
        layer0 = LAYER_IMG; dx0 = img_dx; dy0 = img_dy;
      end else begin
        layer0 = LAYER_BG;
      end
    end
  end

  assign is_key0 = (layer0 == LAYER_KEY_W) || (layer0 == LAYER_KEY_A) ||
                   (layer0 == LAYER_KEY_S) || (layer0 == LAYER_KEY_D);

  logic [3:0] key_lat;
  logic       show_pressed;

`ifdef VGA_KEY_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0] frame_cnt;
  logic            blink_ph;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (bus.frame_start) begin
      if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign show_pressed = key_lat[key_idx] & ~blink_ph;
`else
  assign show_pressed = key_lat[key_idx];
`endif

  logic [2:0]  icon;
  logic [14:0] img_addr_nxt;
  logic [14:0] spr_addr_nxt;

  // Products stay at 15 bits; the largest legal address (19999) fits.
  assign icon         = {show_pressed, key_idx};
  assign img_addr_nxt = 15'(dy0) * 15'(IMG_HE - IMG_HS) + 15'(dx0);
  assign spr_addr_nxt = 15'(icon) * 15'(ICON_WORDS) + 15'(dy0) * 15'(KEY_SZ) + 15'(dx0);

  layer_e tag1, tag2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_lat         <= '0;
      bus.img_addr    <= '0;
      bus.spr_addr    <= '0;
      tag1            <= LAYER_NONE;
      tag2            <= LAYER_NONE;
      bus.pixel       <= '0;
      bus.pixel_valid <= 1'b0;
    end else begin
      // Keys only change at frame boundaries so an icon never tears mid-frame.
      if (bus.frame_start) key_lat <= bus.key_req;

      bus.img_addr <= (layer0 == LAYER_IMG) ? img_addr_nxt : '0;
      bus.spr_addr <= is_key0 ? spr_addr_nxt : '0;
      tag1         <= layer0;
      tag2         <= tag1;

      case (tag2)
        LAYER_KEY_W, LAYER_KEY_A,
        LAYER_KEY_S, LAYER_KEY_D: bus.pixel <= bus.spr_data;
        LAYER_IMG:                bus.pixel <= bus.img_data;
        LAYER_BG:                 bus.pixel <= BG_COLOR;
        default:                  bus.pixel <= '0;
      endcase
      bus.pixel_valid <= (tag2 != LAYER_NONE);
    end
  end

endmodule

// File: tb/tb_vga_layer_sched.sv
// Directed bench for vga_layer_sched with synchronous ROM models on both address ports.
module tb_vga_layer_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  vga_layer_sched_if bus ();

  vga_layer_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Image ROM: one marked word at 361, otherwise low address bits. Sprite ROM: low address bits.
  always @(posedge clk) begin
    bus.img_data <= (bus.img_addr == 15'd361) ? 12'h0a5 : bus.img_addr[11:0];
    bus.spr_data <= bus.spr_addr[11:0];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic run_px(input string tag, input logic vld, input logic [9:0] h,
                        input logic [9:0] v, input logic [14:0] e_img,
                        input logic [14:0] e_spr, input logic [11:0] e_pix,
                        input logic e_pv);
    @(posedge clk); #1;
    bus.valid = vld; bus.h_cnt = h; bus.v_cnt = v;
    @(posedge clk); #1;
    chk({tag, "_img_addr"}, 32'(bus.img_addr), 32'(e_img));
    chk({tag, "_spr_addr"}, 32'(bus.spr_addr), 32'(e_spr));
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_pixel"}, 32'(bus.pixel), 32'(e_pix));
    chk({tag, "_pixel_valid"}, 32'(bus.pixel_valid), 32'(e_pv));
  endtask

  task automatic pulse_frame(input logic [3:0] k);
    @(posedge clk); #1;
    bus.key_req = k; bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.valid       = 1'b1;
    bus.h_cnt       = 10'd61;
    bus.v_cnt       = 10'd62;
    bus.key_req     = 4'b0000;

    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_pixel", 32'(bus.pixel), 32'h0);
      chk("rst_pixel_valid", 32'(bus.pixel_valid), 32'h0);
      chk("rst_img_addr", 32'(bus.img_addr), 32'h0);
      chk("rst_spr_addr", 32'(bus.spr_addr), 32'h0);
    end
    rst_n = 1'b1;

    run_px("img_first", 1'b1, 10'd61,  10'd62,  15'd361,   15'd0, 12'h0a5, 1'b1);
    run_px("img_last",  1'b1, 10'd239, 10'd219, 15'd28799, 15'd0, 12'h07f, 1'b1);
    run_px("img_hend",  1'b1, 10'd240, 10'd100, 15'd0,     15'd0, 12'hfd1, 1'b1);
    run_px("bg",        1'b1, 10'd300, 10'd10,  15'd0,     15'd0, 12'hfd1, 1'b1);
    run_px("invalid",   1'b0, 10'd300, 10'd10,  15'd0,     15'd0, 12'h000, 1'b0);

    run_px("a_idle",    1'b1, 10'd101, 10'd331, 15'd0, 15'd2551, 12'h9f7, 1'b1);
    @(posedge clk); #1;
    bus.key_req = 4'b0010;
    run_px("a_nolatch", 1'b1, 10'd101, 10'd331, 15'd0, 15'd2551, 12'h9f7, 1'b1);
    pulse_frame(4'b0010);
    run_px("a_pressed", 1'b1, 10'd101, 10'd331, 15'd0, 15'd12551, 12'h107, 1'b1);
    bus.key_req = 4'b0000;
    run_px("a_hold",    1'b1, 10'd101, 10'd331, 15'd0, 15'd12551, 12'h107, 1'b1);

    run_px("w_edge",    1'b1, 10'd150, 10'd329, 15'd0, 15'd2450, 12'h992, 1'b1);
    run_px("d_start",   1'b1, 10'd200, 10'd330, 15'd0, 15'd7500, 12'hd4c, 1'b1);
    run_px("d_hend",    1'b1, 10'd250, 10'd330, 15'd0, 15'd0,    12'hfd1, 1'b1);

    // Reset mid-stream with valid background input held throughout.
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_pixel", 32'(bus.pixel), 32'h0);
    chk("mid_rst_pixel_valid", 32'(bus.pixel_valid), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_c1_valid", 32'(bus.pixel_valid), 32'h0);
    @(posedge clk); #1;
    chk("post_rst_c2_valid", 32'(bus.pixel_valid), 32'h0);
    @(posedge clk); #1;
    chk("post_rst_c3_valid", 32'(bus.pixel_valid), 32'h1);
    chk("post_rst_c3_pixel", 32'(bus.pixel), 32'hfd1);
    run_px("a_after_rst", 1'b1, 10'd101, 10'd331, 15'd0, 15'd2551, 12'h9f7, 1'b1);

`ifdef VGA_KEY_BLINK_EN
    pulse_frame(4'b0001);
    run_px("blink_on",  1'b1, 10'd150, 10'd280, 15'd0, 15'd10000, 12'h710, 1'b1);
    repeat (14) pulse_frame(4'b0001);
    run_px("blink_off", 1'b1, 10'd150, 10'd280, 15'd0, 15'd0,     12'h000, 1'b1);
    repeat (15) pulse_frame(4'b0001);
    run_px("blink_back", 1'b1, 10'd150, 10'd280, 15'd0, 15'd10000, 12'h710, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_layer_sched.md
Name: vga_layer_sched

Overview:
- Per-pixel layer scheduler for the VGA overlay path.
- Each pixel it picks one source: a sprite, the camera/status image, or the background colour.
- Four WASD key icons share one single-port sprite ROM. The block computes that ROM's address plus the image ROM address, carries the layer tag through the ROM latency, and emits the final 12-bit pixel.
- Sits between the VGA timing counters and the RGB output register.

Parameters:
- IMG_HS, 60, image window horizontal start (inclusive)
- IMG_HE, 240, image window horizontal end (exclusive)
- IMG_VS, 60, image window vertical start (inclusive)
- IMG_VE, 220, image window vertical end (exclusive)
- KEY_SZ, 50, key icon width and height in pixels
- W_H / W_V, 150 / 280, W icon top-left corner (h / v)
- A_H / A_V, 100 / 330, A icon top-left corner
- S_H / S_V, 150 / 330, S icon top-left corner
- D_H / D_V, 200 / 330, D icon top-left corner
- BG_COLOR, 12'hfd1, colour for valid pixels outside every window
- BLINK_FRAMES, 15, frames per blink phase (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- frame_start  in  1  one-cycle pulse at the start of vertical blank
- valid  in  1  h_cnt/v_cnt lie in the visible area
- h_cnt  in  10  horizontal pixel counter
- v_cnt  in  10  vertical pixel counter
- key_req  in  4  pressed keys, bit order {D,S,A,W}
- img_addr  out  15  image ROM address
- img_data  in  12  image ROM data, valid 1 cycle after img_addr
- spr_addr  out  15  sprite ROM address
- spr_data  in  12  sprite ROM data, valid 1 cycle after spr_addr
- pixel  out  12  final RGB444 pixel
- pixel_valid  out  1  pixel corresponds to a visible position

Behaviour:
- Reset (rst_n=0 at a clk edge): img_addr=0, spr_addr=0, pixel=0, pixel_valid=0, key_lat=0, blink state=0, all pipeline tags = LAYER_NONE.
- Stage 0 (combinational on inputs): hit tests use inclusive start and exclusive end; all arithmetic is unsigned 10-bit.
  - Priority: W > A > S > D > IMG > BG. Overlap is resolved by this priority.
  - If valid=0 the layer is LAYER_NONE.
- Stage 1 (registered, latency 1):
  - img_addr = (v-IMG_VS)*(IMG_HE-IMG_HS) + (h-IMG_HS) when the layer is IMG, else 0.
  - spr_addr = icon*KEY_SZ*KEY_SZ + (v-kv)*KEY_SZ + (h-kh) when the layer is a key, else 0.
  - icon = {pressed, key_idx[1:0]}, where pressed = key_lat[key_idx], so icon ranges 0..7.
  - The ROM holds 8 icons of 2500 words each; the maximum address is 19999, which fits in 15 bits. Products are computed at 15 bits and truncated.
  - The layer tag is registered alongside the address.
- Stage 2: the tag is delayed one more cycle to align with ROM data.
- Stage 3 (registered pixel output), by tag:
  - KEY: pixel = spr_data
  - IMG: pixel = img_data
  - BG: pixel = BG_COLOR
  - NONE: pixel = 0
  - pixel_valid = (tag != NONE).
- Total latency is 3 clk from h_cnt/v_cnt/valid to pixel/pixel_valid. The pipeline runs every cycle with no stalls.
- key_lat:
  - Loads key_req only on clk edges where frame_start=1; otherwise it holds. This prevents tearing mid-frame.
  - If key_req changes in the same cycle as frame_start, the new value is captured.
- Reset asserted mid-frame flushes all tags to NONE. Output stays 0/invalid until 3 cycles after valid input resumes post-reset.
- Counter wrap: no internal pixel counters exist; the block is purely driven by h_cnt/v_cnt.

Optional Feature:
- Macro: VGA_KEY_BLINK_EN.
- Defined:
  - A frame counter counts frame_start pulses 0..BLINK_FRAMES-1, then wraps and toggles blink_ph.
  - When blink_ph=1, pressed icons are shown as their unpressed icon (icon bit2 forced to 0).
  - Counter and blink_ph reset to 0.
- Undefined: no counter logic; pressed icons are always shown pressed.

Decomposition:
- Package vga_layer_pkg holds:
  - layer tag enum: NONE, BG, IMG, KEY_W, KEY_A, KEY_S, KEY_D
  - ICON_WORDS = 2500
  - RGB444 width constant
- One sub-module, vga_win_hit:
  - Parameterised rectangle test.
  - Returns a hit flag and the relative x/y offsets.
  - Instantiated five times: the image window and four keys.

Test Plan:
- Reset: hold rst_n=0 with valid=1 for 4 cycles -> pixel=0, pixel_valid=0, img_addr=0, spr_addr=0 throughout.
- Image window: valid=1, h=61, v=62 -> img_addr=2*180+1=361 one cycle later; ROM returns 12'h0a5 -> pixel=12'h0a5, pixel_valid=1 three cycles after input.
- Background: valid=1, h=300, v=10 -> pixel=12'hfd1 at latency 3; valid=0 -> pixel=0, pixel_valid=0.
- Pressed key, frame-latched: key_req=4'b0010 pulsed with frame_start; then h=101, v=331 (A window, pressed) -> spr_addr=5*2500+1*50+1=12551. With the same key_req but no frame_start yet, the same pixel gives icon 1 -> 2551.
- Priority and boundary: h=150, v=329 -> W window (v-kv=49, h-kh=0) -> spr_addr=0*2500+49*50+0=2450; h=250, v=330 -> outside D (exclusive end) -> BG.
- Blink (VGA_KEY_BLINK_EN defined): key_req=4'b0001 held; after 15 frame_start pulses a W-window pixel switches from icon 4 to icon 0, and returns to icon 4 after 15 more.
